// File: rtl/csl_pkg.sv
// Shared definitions for the console run-control register block:
// register addresses, CTRL/STAT bit positions and FSM state encoding.
package csl_pkg;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_STAT = 2'd1;
    localparam logic [1:0] ADDR_RSV2 = 2'd2;
    localparam logic [1:0] ADDR_RSV3 = 2'd3;

    // CTRL register bits (bus numbering 0:35, bit 35 is the LSB)
    localparam int BIT_RUN  = 35;
    localparam int BIT_CONT = 34;
    localparam int BIT_EXEC = 33;
    localparam int BIT_HIEN = 32;

    // STAT register bits
    localparam int BIT_CPURUN  = 35;
    localparam int BIT_CPUCONT = 34;
    localparam int BIT_CPUEXEC = 33;
    localparam int BIT_CPUHALT = 32;
    localparam int BIT_HEVT    = 31;
    localparam int BIT_TOERR   = 30;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_e;

endpackage

// File: rtl/csl_run_ctrl_edge.sv
// Rising-edge detector for the CPU halt status; the delayed copy is the
// haltD register that reset clears.
module csl_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    // One-cycle delayed copy of the monitored signal
    always_ff @(posedge clk) begin
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig_i;
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/csl_run_ctrl.sv
// Console run-control register block. Turns CTRL writes into a cslSET
// strobe that is held until the CPU clock enable samples it (or a timeout
// expires), and exposes CPU status plus a halt-event interrupt.
//
// state | meaning
// IDLE  | no request outstanding, CTRL writes accepted
// PEND  | cslSET asserted, waiting for clken or timeout
module csl_run_ctrl
    import csl_pkg::*;
#(
    parameter int TOCNT = 1024,
    parameter int TOW   = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clken,
    input  logic        regWR,
    input  logic        regRD,
    input  logic [1:0]  regADDR,
    input  logic [0:35] regDATI,
    output logic [0:35] regDATO,
    output logic        regACK,
    input  logic        cpuRUN,
    input  logic        cpuCONT,
    input  logic        cpuEXEC,
    input  logic        cpuHALT,
    output logic        cslSET,
    output logic        cslRUN,
    output logic        cslCONT,
    output logic        cslEXEC,
    output logic        cslINTR
);

    localparam logic [TOW-1:0] TO_LAST = TOW'(TOCNT - 1);

    state_e          state_q, state_d;
    logic [TOW-1:0]  timer_q, timer_d;
    logic            set_q, set_d;
    logic            run_q, run_d, cont_q, cont_d, exec_q, exec_d, hien_q, hien_d;
    logic            hevt_q, hevt_d, toerr_q, toerr_d;
    logic            intr_q, ack_q, ack_d;
    logic [0:35]     dato_q, dato_d;
    logic            done, to_hit, halt_rise;
    logic            wr_ctrl, wr_stat, rd_only, oth_xfer;
    logic            unused_dati;

    // A simultaneous read is ignored when a write is present.
    assign wr_ctrl  = regWR && (regADDR == ADDR_CTRL);
    assign wr_stat  = regWR && (regADDR == ADDR_STAT);
    assign rd_only  = regRD && !regWR;
    assign oth_xfer = rd_only || (regWR && (regADDR != ADDR_CTRL));

    assign unused_dati = ^regDATI[0:29];

    csl_edge_det u_halt_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (cpuHALT),
        .rise_o (halt_rise)
    );

    // Request FSM: CTRL capture, cslSET hold and timeout
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        set_d   = set_q;
        run_d   = run_q;
        cont_d  = cont_q;
        exec_d  = exec_q;
        hien_d  = hien_q;
        done    = 1'b0;
        to_hit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_ctrl) begin
                    run_d   = regDATI[BIT_RUN];
                    cont_d  = regDATI[BIT_CONT];
                    exec_d  = regDATI[BIT_EXEC];
                    hien_d  = regDATI[BIT_HIEN];
                    set_d   = 1'b1;
                    timer_d = '0;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                // clken on the last timer cycle still counts as success
                if (clken) begin
                    set_d   = 1'b0;
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else if (timer_q == TO_LAST) begin
                    set_d   = 1'b0;
                    done    = 1'b1;
                    to_hit  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TOW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status bits, acknowledge and read data
    always_comb begin
        hevt_d  = hevt_q;
        toerr_d = toerr_q;
        ack_d   = done || oth_xfer;
        dato_d  = '0;
        if (wr_stat) begin
            if (regDATI[BIT_HEVT])  hevt_d  = 1'b0;
            if (regDATI[BIT_TOERR]) toerr_d = 1'b0;
        end
        // New events override a same-cycle clear
        if (halt_rise) hevt_d  = 1'b1;
        if (to_hit)    toerr_d = 1'b1;
        if (rd_only) begin
            case (regADDR)
                ADDR_CTRL: begin
                    dato_d[BIT_RUN]  = run_q;
                    dato_d[BIT_CONT] = cont_q;
                    dato_d[BIT_EXEC] = exec_q;
                    dato_d[BIT_HIEN] = hien_q;
                end
                ADDR_STAT: begin
                    dato_d[BIT_CPURUN]  = cpuRUN;
                    dato_d[BIT_CPUCONT] = cpuCONT;
                    dato_d[BIT_CPUEXEC] = cpuEXEC;
                    dato_d[BIT_CPUHALT] = cpuHALT;
                    dato_d[BIT_HEVT]    = hevt_q;
                    dato_d[BIT_TOERR]   = toerr_q;
                end
                default: dato_d = '0;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            set_q   <= 1'b0;
            run_q   <= 1'b0;
            cont_q  <= 1'b0;
            exec_q  <= 1'b0;
            hien_q  <= 1'b0;
            hevt_q  <= 1'b0;
            toerr_q <= 1'b0;
            intr_q  <= 1'b0;
            ack_q   <= 1'b0;
            dato_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            set_q   <= set_d;
            run_q   <= run_d;
            cont_q  <= cont_d;
            exec_q  <= exec_d;
            hien_q  <= hien_d;
            hevt_q  <= hevt_d;
            toerr_q <= toerr_d;
            intr_q  <= hevt_q & hien_q;
            ack_q   <= ack_d;
            dato_q  <= dato_d;
        end
    end

    assign cslSET  = set_q;
    assign cslRUN  = run_q;
    assign cslCONT = cont_q;
    assign cslEXEC = exec_q;
    assign cslINTR = intr_q;
    assign regACK  = ack_q;
    assign regDATO = dato_q;

endmodule

// File: tb/tb_csl_run_ctrl.sv
// Bench for csl_run_ctrl: a cycle-level behavioural model compared against
// every output each cycle, plus directed scenarios with literal expectations.
module tb_csl_run_ctrl;

    localparam int TOCNT = 24;
    localparam int TOW   = 5;

    logic        clk, rst, clken, regWR, regRD;
    logic [1:0]  regADDR;
    logic [0:35] regDATI, regDATO;
    logic        regACK;
    logic        cpuRUN, cpuCONT, cpuEXEC, cpuHALT;
    logic        cslSET, cslRUN, cslCONT, cslEXEC, cslINTR;

    int n_total = 0;
    int n_pass  = 0;
    logic chk_en = 1'b0;

    csl_run_ctrl #(.TOCNT(TOCNT), .TOW(TOW)) dut (
        .clk     (clk),
        .rst     (rst),
        .clken   (clken),
        .regWR   (regWR),
        .regRD   (regRD),
        .regADDR (regADDR),
        .regDATI (regDATI),
        .regDATO (regDATO),
        .regACK  (regACK),
        .cpuRUN  (cpuRUN),
        .cpuCONT (cpuCONT),
        .cpuEXEC (cpuEXEC),
        .cpuHALT (cpuHALT),
        .cslSET  (cslSET),
        .cslRUN  (cslRUN),
        .cslCONT (cslCONT),
        .cslEXEC (cslEXEC),
        .cslINTR (cslINTR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, want 0x%h at t=%0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // A request is "outstanding" from the cycle after the CTRL write; it ends
    // at the first clken cycle, or TOCNT cycles after it began.
    int          cyc = 0;
    int          m_pstart = 0;
    logic        m_out, m_run, m_cont, m_exec, m_hien;
    logic        m_hevt, m_toerr, m_intr, m_ack, m_hprev;
    logic [0:35] m_dato;

    always @(posedge clk) begin : model
        logic [0:35] rd;
        logic        ack_n, timed_out, rise, rd_en;
        if (rst) begin
            m_out = 0; m_run = 0; m_cont = 0; m_exec = 0; m_hien = 0;
            m_hevt = 0; m_toerr = 0; m_intr = 0; m_ack = 0; m_hprev = 0;
            m_dato = '0;
        end else begin
            rise      = cpuHALT && !m_hprev;
            rd_en     = regRD && !regWR;
            rd        = '0;
            timed_out = 0;
            ack_n     = rd_en || (regWR && regADDR != 2'd0);
            if (rd_en && regADDR == 2'd0) begin
                rd[35] = m_run; rd[34] = m_cont; rd[33] = m_exec; rd[32] = m_hien;
            end else if (rd_en && regADDR == 2'd1) begin
                rd[35] = cpuRUN; rd[34] = cpuCONT; rd[33] = cpuEXEC; rd[32] = cpuHALT;
                rd[31] = m_hevt; rd[30] = m_toerr;
            end
            m_intr = m_hevt && m_hien;
            if (m_out) begin
                if (clken) begin
                    m_out = 0; ack_n = 1;
                end else if (cyc - m_pstart == TOCNT - 1) begin
                    m_out = 0; ack_n = 1; timed_out = 1;
                end
            end else if (regWR && regADDR == 2'd0) begin
                m_run = regDATI[35]; m_cont = regDATI[34];
                m_exec = regDATI[33]; m_hien = regDATI[32];
                m_out = 1; m_pstart = cyc + 1;
            end
            m_hevt  = (m_hevt  && !(regWR && regADDR == 2'd1 && regDATI[31])) || rise;
            m_toerr = (m_toerr && !(regWR && regADDR == 2'd1 && regDATI[30])) || timed_out;
            m_ack   = ack_n;
            m_dato  = rd;
            m_hprev = cpuHALT;
        end
        cyc++;
    end

    // Compare all outputs against the model on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_cslSET",  36'(cslSET),  36'(m_out));
            chk("m_cslRUN",  36'(cslRUN),  36'(m_run));
            chk("m_cslCONT", 36'(cslCONT), 36'(m_cont));
            chk("m_cslEXEC", 36'(cslEXEC), 36'(m_exec));
            chk("m_cslINTR", 36'(cslINTR), 36'(m_intr));
            chk("m_regACK",  36'(regACK),  36'(m_ack));
            chk("m_regDATO", regDATO,      m_dato);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:35] mk(input logic r, input logic c, input logic e, input logic h);
        logic [0:35] d;
        d = '0;
        d[35] = r; d[34] = c; d[33] = e; d[32] = h;
        return d;
    endfunction

    task automatic wr_reg(input logic [1:0] a, input logic [0:35] d);
        regWR = 1; regADDR = a; regDATI = d;
        tick();
        regWR = 0; regDATI = '0;
    endtask

    // Leaves the bench in the cycle where the ack is due
    task automatic rd_reg(input string nm, input logic [1:0] a, output logic [0:35] d);
        regRD = 1; regADDR = a;
        tick();
        regRD = 0;
        chk({nm, "_ack"}, 36'(regACK), 36'd1);
        d = regDATO;
    endtask

    initial begin : stim
        logic [0:35] d, w1c;
        int hi, acks;
        rst = 1; clken = 1; regWR = 0; regRD = 0; regADDR = 0; regDATI = '0;
        cpuRUN = 0; cpuCONT = 0; cpuEXEC = 0; cpuHALT = 0;
        tick();
        chk_en = 1;
        tick();
        chk("rst_set",  36'(cslSET),  36'd0);
        chk("rst_ack",  36'(regACK),  36'd0);
        chk("rst_intr", 36'(cslINTR), 36'd0);
        chk("rst_dato", regDATO,      36'd0);
        rst = 0;
        tick();

        // 1: clken steady, CTRL = RUN|CONT
        wr_reg(2'd0, mk(1, 1, 0, 0));
        chk("t1_set_hi", 36'(cslSET),  36'd1);
        chk("t1_run",    36'(cslRUN),  36'd1);
        chk("t1_cont",   36'(cslCONT), 36'd1);
        chk("t1_exec",   36'(cslEXEC), 36'd0);
        chk("t1_noack",  36'(regACK),  36'd0);
        tick();
        chk("t1_set_lo", 36'(cslSET), 36'd0);
        chk("t1_ack",    36'(regACK), 36'd1);
        tick();
        chk("t1_ack_once", 36'(regACK), 36'd0);

        // 2: clken low 20 cycles
        clken = 0;
        wr_reg(2'd0, mk(0, 0, 1, 0));
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (cslSET) hi++;
            if (i == 19) clken = 1;
            tick();
        end
        chk("t2_set_cycles", 36'(hi), 36'd20);
        chk("t2_set_lo",     36'(cslSET),  36'd0);
        chk("t2_ack",        36'(regACK),  36'd1);
        chk("t2_exec",       36'(cslEXEC), 36'd1);
        chk("t2_run",        36'(cslRUN),  36'd0);
        rd_reg("t2_stat", 2'd1, d);
        chk("t2_toerr", 36'(d[30]), 36'd0);

        // 3: timeout after TOCNT cycles
        clken = 0;
        wr_reg(2'd0, mk(1, 0, 0, 0));
        hi = 0; acks = 0;
        for (int i = 0; i < TOCNT + 6; i++) begin
            if (cslSET) hi++;
            if (regACK) acks++;
            tick();
        end
        chk("t3_set_cycles", 36'(hi),   36'(TOCNT));
        chk("t3_ack_count",  36'(acks), 36'd1);
        rd_reg("t3_stat", 2'd1, d);
        chk("t3_toerr_set", 36'(d[30]), 36'd1);
        w1c = '0; w1c[30] = 1;
        wr_reg(2'd1, w1c);
        rd_reg("t3_stat2", 2'd1, d);
        chk("t3_toerr_clr", 36'(d[30]), 36'd0);

        // 3b: clken on the final timer cycle is a success
        wr_reg(2'd0, mk(0, 1, 0, 0));
        for (int i = 0; i < TOCNT - 1; i++) tick();
        clken = 1;
        tick();
        chk("t3b_set_lo", 36'(cslSET),  36'd0);
        chk("t3b_ack",    36'(regACK),  36'd1);
        chk("t3b_cont",   36'(cslCONT), 36'd1);
        rd_reg("t3b_stat", 2'd1, d);
        chk("t3b_toerr", 36'(d[30]), 36'd0);

        // 4: halt event interrupt and set-beats-clear
        wr_reg(2'd0, mk(0, 0, 0, 1));
        tick(); tick();
        cpuHALT = 1;
        tick(); tick();
        chk("t4_intr", 36'(cslINTR), 36'd1);
        rd_reg("t4_stat", 2'd1, d);
        chk("t4_hevt", 36'(d[31]), 36'd1);
        cpuHALT = 0;
        tick();
        cpuHALT = 1;
        w1c = '0; w1c[31] = 1;
        wr_reg(2'd1, w1c);
        rd_reg("t4_stat2", 2'd1, d);
        chk("t4_hevt_kept", 36'(d[31]), 36'd1);
        wr_reg(2'd1, w1c);
        rd_reg("t4_stat3", 2'd1, d);
        chk("t4_hevt_clr", 36'(d[31]), 36'd0);
        tick();
        chk("t4_intr_lo", 36'(cslINTR), 36'd0);

        // 5: status readback and reserved addresses
        cpuRUN = 1;
        regRD = 1; regADDR = 2'd1;
        chk("t5_noack_strobe", 36'(regACK), 36'd0);
        tick();
        regRD = 0;
        chk("t5_ack", 36'(regACK), 36'd1);
        d = '0; d[35] = 1; d[32] = 1;
        chk("t5_stat", regDATO, d);
        rd_reg("t5_addr3", 2'd3, d);
        chk("t5_addr3_data", d, 36'd0);
        rd_reg("t5_ctrl", 2'd0, d);
        chk("t5_ctrl_data", d, mk(0, 0, 0, 1));
        regWR = 1; regRD = 1; regADDR = 2'd2; regDATI = '1;
        tick();
        regWR = 0; regRD = 0; regDATI = '0;
        chk("t5_rw_ack",  36'(regACK),  36'd1);
        chk("t5_rw_data", regDATO,      36'd0);
        tick();
        chk("t5_rw_once", 36'(regACK), 36'd0);

        // 6: reset while a request is outstanding
        cpuRUN = 0; cpuHALT = 0; clken = 0;
        wr_reg(2'd0, mk(1, 1, 1, 0));
        tick(); tick(); tick();
        chk("t6_pend", 36'(cslSET), 36'd1);
        rst = 1;
        tick();
        chk("t6_set_lo", 36'(cslSET),  36'd0);
        chk("t6_noack",  36'(regACK),  36'd0);
        chk("t6_run",    36'(cslRUN),  36'd0);
        rst = 0; clken = 1;
        tick();
        chk("t6_noack2", 36'(regACK), 36'd0);
        rd_reg("t6_stat", 2'd1, d);
        chk("t6_stat_zero", d, 36'd0);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
